// File: rtl/seg7_scroll_sequencer.sv
// Scrolling-message controller for a 4-digit seven-segment display: stores the
// message, sequences scroll offset, blink phase and digit scan, all on one clock.
module seg7_scroll_sequencer #(
   parameter int MSG_LEN     = 18,
   parameter int SCAN_DIV    = 32768,
   parameter int STEP_DIV    = 16777216,
   parameter int BLINK_DIV   = 2097152,
   parameter int SWING_STEPS = 15
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       load_valid_i,
   input  logic [3:0] load_data_i,
   output logic       load_ready_o,
   input  logic       speed_i,
   input  logic       swing_i,
   input  logic       dir_i,
   input  logic       blink_en_i,
   output logic [3:0] digit_sel_o,
   output logic [3:0] nibble_o,
   output logic       blank_o,
   output logic       busy_o
);

   localparam int PTR_W   = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
   localparam int SUM_W   = PTR_W + 1;
   localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int STEP_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int SWING_W = (SWING_STEPS > 1) ? $clog2(SWING_STEPS + 1) : 1;

   localparam logic [PTR_W-1:0]   LAST_PTR       = PTR_W'(MSG_LEN - 1);
   localparam logic [SUM_W-1:0]   LEN_SUM        = SUM_W'(MSG_LEN);
   localparam logic [SCAN_W-1:0]  SCAN_LAST      = SCAN_W'(SCAN_DIV - 1);
   localparam logic [STEP_W-1:0]  STEP_LAST_SLOW = STEP_W'(STEP_DIV - 1);
   localparam logic [STEP_W-1:0]  STEP_LAST_FAST = STEP_W'(STEP_DIV / 2 - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST     = BLINK_W'(BLINK_DIV - 1);
   localparam logic [SWING_W-1:0] SWING_LAST     = SWING_W'(SWING_STEPS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } stateT;

   stateT              state_q, state_d;
   logic [3:0]         msgBuf_q [MSG_LEN];
   logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]   wrAddr;
   logic [PTR_W-1:0]   offset_q, offset_d;
   logic [1:0]         idx_q, idx_d;
   logic [SCAN_W-1:0]  scanCnt_q, scanCnt_d;
   logic [STEP_W-1:0]  stepCnt_q, stepCnt_d;
   logic [STEP_W-1:0]  stepLast;
   logic [BLINK_W-1:0] blinkCnt_q, blinkCnt_d;
   logic               blinkPh_q, blinkPh_d;
   logic [SWING_W-1:0] swingCnt_q, swingCnt_d;
   logic               swingDir_q, swingDir_d;
   logic               moveLeft;
   logic [SUM_W-1:0]   rdSum, rdWrapped;
   logic [PTR_W-1:0]   rdAddr;
   logic               showing;
   logic [3:0]         digitSel_q, digitSel_d;
   logic [3:0]         nibble_q, nibble_d;
   logic               blank_q, blank_d;
   logic               busy_q, busy_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Any accepted nibble outside LOAD starts a fresh message, aborting RUN.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (load_valid_i) state_d = LOAD;
         end
         LOAD: begin
            if (load_valid_i && (wrPtr_q == LAST_PTR)) state_d = RUN;
         end
         RUN: begin
            if (load_valid_i) state_d = LOAD;
         end
         default: state_d = IDLE;
      endcase
   end

   assign wrAddr = (state_q == LOAD) ? wrPtr_q : '0;

   always_ff @(posedge clk_i) begin
      if (!rst_i && load_valid_i) begin
         msgBuf_q[wrAddr] <= load_data_i;
      end
   end

   always_comb begin
      wrPtr_d    = wrPtr_q;
      offset_d   = offset_q;
      idx_d      = idx_q;
      scanCnt_d  = scanCnt_q;
      stepCnt_d  = stepCnt_q;
      swingCnt_d = swingCnt_q;
      swingDir_d = swingDir_q;
      stepLast   = speed_i ? STEP_LAST_FAST : STEP_LAST_SLOW;
      moveLeft   = swing_i ? ~swingDir_q : ~dir_i;
      case (state_q)
         RUN: begin
            if (load_valid_i) begin
               wrPtr_d   = PTR_W'(1);
               idx_d     = '0;
               scanCnt_d = '0;
               stepCnt_d = '0;
            end else begin
               if (scanCnt_q == SCAN_LAST) begin
                  scanCnt_d = '0;
                  idx_d     = idx_q + 2'd1;
               end else begin
                  scanCnt_d = scanCnt_q + 1'b1;
               end
               // A >= compare also catches a count stranded above a shorter fast period.
               if (stepCnt_q >= stepLast) begin
                  stepCnt_d = '0;
                  if (moveLeft) begin
                     offset_d = (offset_q == LAST_PTR) ? '0 : offset_q + 1'b1;
                  end else begin
                     offset_d = (offset_q == '0) ? LAST_PTR : offset_q - 1'b1;
                  end
                  if (swing_i) begin
                     if (swingCnt_q == SWING_LAST) begin
                        swingCnt_d = '0;
                        swingDir_d = ~swingDir_q;
                     end else begin
                        swingCnt_d = swingCnt_q + 1'b1;
                     end
                  end
               end else begin
                  stepCnt_d = stepCnt_q + 1'b1;
               end
            end
         end
         LOAD: begin
            idx_d     = '0;
            scanCnt_d = '0;
            stepCnt_d = '0;
            if (load_valid_i) begin
               if (wrPtr_q == LAST_PTR) begin
                  wrPtr_d    = '0;
                  offset_d   = '0;
                  swingCnt_d = '0;
                  swingDir_d = 1'b0;
               end else begin
                  wrPtr_d = wrPtr_q + 1'b1;
               end
            end
         end
         default: begin
            idx_d     = '0;
            scanCnt_d = '0;
            stepCnt_d = '0;
            if (load_valid_i) wrPtr_d = PTR_W'(1);
         end
      endcase
      if (!swing_i) swingCnt_d = '0;
   end

   always_comb begin
      blinkCnt_d = blinkCnt_q;
      blinkPh_d  = blinkPh_q;
      if (!blink_en_i || (state_q != RUN)) begin
         blinkCnt_d = '0;
         blinkPh_d  = 1'b0;
      end else if (blinkCnt_q == BLINK_LAST) begin
         blinkCnt_d = '0;
         blinkPh_d  = ~blinkPh_q;
      end else begin
         blinkCnt_d = blinkCnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wrPtr_q    <= '0;
         offset_q   <= '0;
         idx_q      <= '0;
         scanCnt_q  <= '0;
         stepCnt_q  <= '0;
         blinkCnt_q <= '0;
         blinkPh_q  <= 1'b0;
         swingCnt_q <= '0;
         swingDir_q <= 1'b0;
      end else begin
         wrPtr_q    <= wrPtr_d;
         offset_q   <= offset_d;
         idx_q      <= idx_d;
         scanCnt_q  <= scanCnt_d;
         stepCnt_q  <= stepCnt_d;
         blinkCnt_q <= blinkCnt_d;
         blinkPh_q  <= blinkPh_d;
         swingCnt_q <= swingCnt_d;
         swingDir_q <= swingDir_d;
      end
   end

   // Digit idx shows character offset+(3-idx); 3-idx of a 2-bit value is its inverse.
   always_comb begin
      rdSum     = {1'b0, offset_q} + {{(SUM_W - 2){1'b0}}, ~idx_q};
      rdWrapped = (rdSum >= LEN_SUM) ? (rdSum - LEN_SUM) : rdSum;
      rdAddr    = rdWrapped[PTR_W-1:0];
   end

   always_comb begin
      showing    = (state_q == RUN) && !(blinkPh_q && blink_en_i);
      digitSel_d = showing ? ~(4'b0001 << idx_q) : 4'b1111;
      blank_d    = !showing;
      nibble_d   = (state_q == RUN) ? msgBuf_q[rdAddr] : 4'h0;
      busy_d     = (state_d == LOAD);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         digitSel_q <= 4'b1111;
         nibble_q   <= 4'h0;
         blank_q    <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         digitSel_q <= digitSel_d;
         nibble_q   <= nibble_d;
         blank_q    <= blank_d;
         busy_q     <= busy_d;
      end
   end

   assign load_ready_o = 1'b1;
   assign digit_sel_o  = digitSel_q;
   assign nibble_o     = nibble_q;
   assign blank_o      = blank_q;
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_seg7_scroll_sequencer.sv
// Directed self-checking bench for seg7_scroll_sequencer with short dividers
// (scan 4, step 64, blink 16, 18-nibble message).
module tb_seg7_scroll_sequencer;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       load_valid_i = 1'b0;
   logic [3:0] load_data_i = 4'h0;
   logic       load_ready_o;
   logic       speed_i = 1'b0;
   logic       swing_i = 1'b0;
   logic       dir_i = 1'b0;
   logic       blink_en_i = 1'b0;
   logic [3:0] digit_sel_o;
   logic [3:0] nibble_o;
   logic       blank_o;
   logic       busy_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int blankCount;
   bit jitterDir = 1'b0;

   localparam logic [71:0] MSG_A = 72'h150114022150114026;
   localparam logic [71:0] MSG_B = 72'h0123456789ABCDEF01;

   seg7_scroll_sequencer #(
      .MSG_LEN    (18),
      .SCAN_DIV   (4),
      .STEP_DIV   (64),
      .BLINK_DIV  (16),
      .SWING_STEPS(15)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .load_valid_i(load_valid_i),
      .load_data_i (load_data_i),
      .load_ready_o(load_ready_o),
      .speed_i     (speed_i),
      .swing_i     (swing_i),
      .dir_i       (dir_i),
      .blink_en_i  (blink_en_i),
      .digit_sel_o (digit_sel_o),
      .nibble_o    (nibble_o),
      .blank_o     (blank_o),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic stepClk(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i);
         #1;
         cyc++;
         if (jitterDir) dir_i = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic goTo(input int t);
      if (t > cyc) stepClk(t - cyc);
   endtask

   task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   task automatic checkFlag(input string tag, input logic observed, input logic expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   task automatic checkCount(input string tag, input int observed, input int expected);
      checks++;
      assert (observed == expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkLeft(input string tag, input logic [3:0] expected);
      checkOutput({tag, "_sel"}, digit_sel_o, 4'b0111);
      checkOutput({tag, "_nib"}, nibble_o, expected);
   endtask

   // Streams 18 nibbles MSB first; cyc is zero right after the final accept.
   task automatic applyStimulus(input logic [71:0] msg);
      for (int i = 0; i < 18; i++) begin
         load_valid_i = 1'b1;
         load_data_i  = msg[71 - 4*i -: 4];
         stepClk(1);
         if (i == 0) checkFlag("busy_first_accept", busy_o, 1'b1);
         if (i == 1) begin
            checkFlag("blank_in_load", blank_o, 1'b1);
            checkOutput("sel_in_load", digit_sel_o, 4'b1111);
         end
      end
      load_valid_i = 1'b0;
      checkFlag("busy_after_load", busy_o, 1'b0);
      cyc = 0;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      stepClk(2);
      checkOutput("rst_sel", digit_sel_o, 4'b1111);
      checkOutput("rst_nib", nibble_o, 4'h0);
      checkFlag("rst_blank", blank_o, 1'b1);
      checkFlag("rst_busy", busy_o, 1'b0);
      checkFlag("rst_ready", load_ready_o, 1'b1);
      rst_i = 1'b0;
      stepClk(5);
      checkFlag("idle_busy", busy_o, 1'b0);
      checkFlag("idle_blank", blank_o, 1'b1);

      $display("[TB] load and scan round");
      applyStimulus(MSG_A);
      goTo(1);
      checkOutput("scan0_sel", digit_sel_o, 4'b1110);
      checkOutput("scan0_nib", nibble_o, 4'h1);
      checkFlag("scan0_blank", blank_o, 1'b0);
      goTo(5);
      checkOutput("scan1_sel", digit_sel_o, 4'b1101);
      checkOutput("scan1_nib", nibble_o, 4'h0);
      goTo(9);
      checkOutput("scan2_sel", digit_sel_o, 4'b1011);
      checkOutput("scan2_nib", nibble_o, 4'h5);
      goTo(13);
      checkLeft("scan3", 4'h1);

      $display("[TB] left scroll");
      goTo(64);
      checkLeft("left_pre_step", 4'h1);
      goTo(77);
      checkLeft("left_off1", 4'h5);
      goTo(1149);
      checkLeft("left_off17", 4'h6);
      goTo(1165);
      checkLeft("left_wrap0", 4'h1);
      speed_i = 1'b1;
      goTo(1197);
      checkLeft("fast_off1", 4'h5);
      goTo(1229);
      checkLeft("fast_off2", 4'h0);
      goTo(1261);
      checkLeft("fast_off3", 4'h1);

      $display("[TB] reload and right scroll");
      dir_i = 1'b1;
      applyStimulus(MSG_A);
      goTo(29);
      checkLeft("right_off0", 4'h1);
      goTo(45);
      checkLeft("right_off17", 4'h6);
      goTo(77);
      checkLeft("right_off16", 4'h2);

      $display("[TB] swing");
      swing_i = 1'b1;
      jitterDir = 1'b1;
      applyStimulus(MSG_A);
      goTo(237);
      checkLeft("swing_off7", 4'h2);
      goTo(493);
      checkLeft("swing_off15", 4'h0);
      goTo(525);
      checkLeft("swing_off14", 4'h4);
      goTo(957);
      checkLeft("swing_off1", 4'h5);
      goTo(973);
      checkLeft("swing_off0", 4'h1);
      goTo(1005);
      checkLeft("swing_back1", 4'h5);
      jitterDir = 1'b0;
      swing_i = 1'b0;
      dir_i = 1'b0;

      $display("[TB] blink");
      blink_en_i = 1'b1;
      cyc = 0;
      goTo(16);
      checkFlag("blink_vis16", blank_o, 1'b0);
      goTo(17);
      checkFlag("blink_off17", blank_o, 1'b1);
      checkOutput("blink_sel17", digit_sel_o, 4'b1111);
      goTo(32);
      checkFlag("blink_off32", blank_o, 1'b1);
      goTo(33);
      checkFlag("blink_vis33", blank_o, 1'b0);
      blankCount = 0;
      for (int i = 0; i < 32; i++) begin
         stepClk(1);
         if (blank_o === 1'b1) blankCount++;
      end
      checkCount("blink_duty", blankCount, 16);
      goTo(85);
      checkFlag("blink_off85", blank_o, 1'b1);
      blink_en_i = 1'b0;
      goTo(86);
      checkFlag("blink_clear", blank_o, 1'b0);
      goTo(110);
      checkFlag("blink_stays_clear", blank_o, 1'b0);

      $display("[TB] reset mid-load");
      load_valid_i = 1'b1;
      load_data_i  = 4'hA;
      stepClk(5);
      checkFlag("partial_busy", busy_o, 1'b1);
      load_valid_i = 1'b0;
      rst_i = 1'b1;
      stepClk(1);
      rst_i = 1'b0;
      checkFlag("midload_rst_busy", busy_o, 1'b0);
      checkFlag("midload_rst_blank", blank_o, 1'b1);
      checkOutput("midload_rst_sel", digit_sel_o, 4'b1111);
      checkOutput("midload_rst_nib", nibble_o, 4'h0);
      stepClk(40);
      checkFlag("idle_hold_busy", busy_o, 1'b0);
      checkFlag("idle_hold_blank", blank_o, 1'b1);
      applyStimulus(MSG_B);
      goTo(1);
      checkOutput("msgb_sel0", digit_sel_o, 4'b1110);
      checkOutput("msgb_nib0", nibble_o, 4'h3);
      goTo(13);
      checkLeft("msgb_left", 4'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
